// File: rtl/ice_input_conditioner.sv
// ice_input_conditioner
//   Button front end for the 12 MHz board. A shared divider produces a slow
//   enable tick. Each channel then runs through the same chain: an optional
//   inversion, a 2-flop synchroniser, a tick-based debouncer, edge pulses,
//   and a one-shot long-press detector.
//
// Ports
//   clk        single clock; all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   ena        global enable for the tick divider
//   i_btn      raw asynchronous button pins, N_CH wide
//   o_tick     one-clk strobe every DIV enabled cycles
//   o_level    debounced, active-high button state
//   o_press    one-clk pulse when an accepted 0->1 change appears on o_level
//   o_release  one-clk pulse when an accepted 1->0 change appears on o_level
//   o_long     one-clk pulse after o_level has been high for LONG_TICKS ticks
module ice_input_conditioner #(
    parameter int              N_CH       = 3,
    parameter int              DIV        = 12,
    parameter int              DB_TICKS   = 1000,
    parameter int              LONG_TICKS = 500000,
    parameter logic [N_CH-1:0] INVERT     = {N_CH{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [N_CH-1:0] i_btn,
    output logic            o_tick,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic [N_CH-1:0] o_long
);

    localparam int               DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);

    localparam int              DB_W   = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_TICKS - 1);

    // The long counter has to hold LONG_TICKS itself, because it saturates there.
    localparam int              LG_W   = $clog2(LONG_TICKS + 1);
    localparam logic [LG_W-1:0] LG_MAX = LG_W'(LONG_TICKS);
    localparam logic [LG_W-1:0] LG_PRE = LG_W'(LONG_TICKS - 1);

    // ---------------- tick divider ----------------
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    // The tick is combinational, so it drops in the same cycle that ena drops.
    // With DIV=1, div_q stays 0 and the tick simply follows ena.
    always_comb begin
        div_d = div_q;
        tick  = ena && (div_q == DIV_MAX);
        if (ena) div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_q <= '0;
        else        div_q <= div_d;
    end

    assign o_tick = tick;

    // ---------------- per-channel lanes ----------------
    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        logic [1:0]      sync_q, sync_d;
        logic [DB_W-1:0] db_q, db_d;
        logic [LG_W-1:0] lg_q, lg_d;
        logic            level_q, level_d;
        logic            press_q, press_d;
        logic            rel_q, rel_d;
        logic            lp_q, lp_d;

        always_comb begin
            sync_d  = {sync_q[0], i_btn[g] ^ INVERT[g]};
            level_d = level_q;
            db_d    = db_q;
            lg_d    = lg_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            lp_d    = 1'b0;

            // Debounce: any cycle that agrees with the current level clears
            // the count, so only an unbroken run of differing ticks can flip
            // the level. The edge pulses are registered together with the
            // level, which keeps them aligned with the change on o_level.
            if (sync_q[1] == level_q) begin
                db_d = '0;
            end else if (tick) begin
                if (db_q == DB_MAX) begin
                    level_d = ~level_q;
                    db_d    = '0;
                    press_d = ~level_q;
                    rel_d   = level_q;
                end else begin
                    db_d = db_q + DB_W'(1);
                end
            end

            // Long press: the counter saturates at LONG_TICKS and the pulse
            // fires only on the step that reaches it, so it cannot repeat
            // until a release clears the counter.
            if (!level_q) begin
                lg_d = '0;
            end else if (tick && (lg_q != LG_MAX)) begin
                lg_d = lg_q + LG_W'(1);
                lp_d = (lg_q == LG_PRE);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q  <= '0;
                db_q    <= '0;
                lg_q    <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                lp_q    <= 1'b0;
            end else begin
                sync_q  <= sync_d;
                db_q    <= db_d;
                lg_q    <= lg_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                lp_q    <= lp_d;
            end
        end

        assign o_level[g]   = level_q;
        assign o_press[g]   = press_q;
        assign o_release[g] = rel_q;
        assign o_long[g]    = lp_q;
    end

endmodule

// File: tb/tb_ice_input_conditioner.sv
// Directed bench for ice_input_conditioner.
// Settings: N_CH=3, DIV=4, DB_TICKS=3, LONG_TICKS=5, INVERT=3'b100.
module tb_ice_input_conditioner;

    localparam int SEL_PRESS = 0;
    localparam int SEL_REL   = 1;
    localparam int SEL_LONG  = 2;
    localparam int SEL_TICK  = 3;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [2:0] i_btn;
    logic       o_tick;
    logic [2:0] o_level, o_press, o_release, o_long;

    int tests = 0;
    int fails = 0;
    int press_cnt [3];
    int rel_cnt   [3];
    int long_cnt  [3];

    ice_input_conditioner #(
        .N_CH(3), .DIV(4), .DB_TICKS(3), .LONG_TICKS(5), .INVERT(3'b100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .i_btn(i_btn),
        .o_tick(o_tick), .o_level(o_level), .o_press(o_press),
        .o_release(o_release), .o_long(o_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every pulse, so that a repeated or stretched pulse shows up in
    // the totals.
    initial begin
        for (int i = 0; i < 3; i++) begin
            press_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (o_press[i])   press_cnt[i]++;
            if (o_release[i]) rel_cnt[i]++;
            if (o_long[i])    long_cnt[i]++;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic sig(input int sel, input int ch);
        case (sel)
            SEL_PRESS: return o_press[ch];
            SEL_REL:   return o_release[ch];
            SEL_LONG:  return o_long[ch];
            default:   return o_tick;
        endcase
    endfunction

    // Returns the number of edges until the signal is first seen high, or
    // lim+1 if it never is.
    task automatic wait_for(input int sel, input int ch, input int lim, output int n);
        n = lim + 1;
        for (int k = 1; k <= lim; k++) begin
            @(posedge clk);
            #1;
            if (sig(sel, ch)) begin
                n = k;
                break;
            end
        end
    endtask

    // Leaves the bench just after an edge where o_tick is high (divider = 3).
    task automatic align(input string tag);
        int n;
        wait_for(SEL_TICK, 0, 8, n);
        if (n > 8) chk(tag, n, 4);
    endtask

    initial begin
        int n;
        rst_n = 1'b1;
        ena   = 1'b0;
        i_btn = 3'b100;   // ch2 is active-low, so 1 means idle
        #1 rst_n = 1'b0;

        // ---- reset state ----
        cyc(3);
        chk("rst_tick",    o_tick,    0);
        chk("rst_level",   o_level,   0);
        chk("rst_press",   o_press,   0);
        chk("rst_release", o_release, 0);
        chk("rst_long",    o_long,    0);

        // ---- divider ----
        rst_n = 1'b1;
        ena   = 1'b1;
        wait_for(SEL_TICK, 0, 20, n);
        chk("first_tick_edges", n, 3);
        wait_for(SEL_TICK, 0, 20, n);
        chk("tick_period", n, 4);
        ena = 1'b0;
        #1;
        chk("tick_gated_by_ena", o_tick, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            chk("tick_while_disabled", o_tick, 0);
        end
        ena = 1'b1;
        #1;
        chk("tick_phase_resumes", o_tick, 1);
        wait_for(SEL_TICK, 0, 20, n);
        chk("tick_period_after_resume", n, 4);

        // ---- clean press on ch0 (2 sync edges + 3 ticks) ----
        i_btn[0] = 1'b1;
        wait_for(SEL_PRESS, 0, 50, n);
        chk("press0_latency", n, 13);
        chk("press0_level", o_level[0], 1);
        cyc(1);
        chk("press0_one_cycle", o_press[0], 0);
        chk("press0_count",  press_cnt[0], 1);
        chk("press0_no_rel", rel_cnt[0],   0);
        chk("press0_no_long", long_cnt[0], 0);

        // ---- long press: 5 ticks after acceptance, then silence ----
        wait_for(SEL_LONG, 0, 100, n);
        chk("long0_latency", n, 19);
        cyc(80);
        chk("long0_single", long_cnt[0], 1);
        chk("long0_level_held", o_level[0], 1);

        // ---- release ch0 ----
        align("align_rel0");
        i_btn[0] = 1'b0;
        wait_for(SEL_REL, 0, 50, n);
        chk("rel0_latency", n, 13);
        chk("rel0_level", o_level[0], 0);
        cyc(1);
        chk("rel0_count",   rel_cnt[0],   1);
        chk("rel0_press_count", press_cnt[0], 1);

        // ---- bounce on ch1: 2 ticks high, then low ----
        align("align_bounce");
        i_btn[1] = 1'b1;
        cyc(9);
        i_btn[1] = 1'b0;
        cyc(40);
        chk("bounce1_level", o_level[1], 0);
        chk("bounce1_no_press", press_cnt[1], 0);
        chk("bounce1_no_rel",   rel_cnt[1],   0);

        align("align_press1");
        i_btn[1] = 1'b1;
        wait_for(SEL_PRESS, 1, 50, n);
        chk("press1_latency", n, 13);
        align("align_rel1");
        i_btn[1] = 1'b0;
        wait_for(SEL_REL, 1, 50, n);
        chk("rel1_latency", n, 13);
        chk("ch1_no_long", long_cnt[1], 0);

        // ---- inverted ch2 pressed together with ch1 ----
        align("align_simul");
        i_btn = 3'b010;
        wait_for(SEL_PRESS, 1, 50, n);
        chk("simul_latency", n, 13);
        chk("simul_press", o_press, 3'b110);
        chk("simul_level", o_level, 3'b110);
        align("align_simul_rel");
        i_btn = 3'b100;
        wait_for(SEL_REL, 1, 50, n);
        chk("simul_rel_latency", n, 13);
        chk("simul_release", o_release, 3'b110);
        cyc(1);
        chk("ch2_press_count", press_cnt[2], 1);
        chk("ch2_rel_count",   rel_cnt[2],   1);
        chk("ch2_no_long",     long_cnt[2],  0);

        // ---- reset during the second debounce tick of ch0 ----
        align("align_rst");
        i_btn[0] = 1'b1;
        cyc(8);
        chk("pre_reset_tick", o_tick, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_tick",  o_tick,    0);
        chk("midrst_level", o_level,   0);
        chk("midrst_press", o_press,   0);
        chk("midrst_rel",   o_release, 0);
        chk("midrst_long",  o_long,    0);
        cyc(2);
        rst_n = 1'b1;
        wait_for(SEL_PRESS, 0, 50, n);
        chk("press_after_reset_latency", n, 12);
        chk("press_after_reset_level", o_level[0], 1);
        cyc(1);
        chk("press0_total", press_cnt[0], 2);
        chk("rel0_total",   rel_cnt[0],   1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ice_input_conditioner.md
ICE_INPUT_CONDITIONER -- requirements
Module: ice_input_conditioner

Interface
REQ-001 SHALL have parameter N_CH, default 3: number of independent button channels (1..8).
REQ-002 SHALL have parameter DIV, default 12: o_tick period in clk cycles (>=1); 12 gives 1 MHz from the 12 MHz board clock.
REQ-003 SHALL have parameter DB_TICKS, default 1000: consecutive ticks of changed input required to accept a new level (>=1).
REQ-004 SHALL have parameter LONG_TICKS, default 500000: ticks of accepted high level before a long-press pulse (>=1).
REQ-005 SHALL have parameter INVERT, default {N_CH{1'b0}}: per-channel mask; a 1 treats that input as active-low.
REQ-006 SHALL have clk input, width 1: single clock; all state is on its rising edge.
REQ-007 SHALL have rst_n input, width 1: asynchronous, active-low reset.
REQ-008 SHALL have ena input, width 1: global enable for the tick divider.
REQ-009 SHALL have i_btn input, width N_CH: raw, asynchronous button pins.
REQ-010 SHALL have o_tick output, width 1: one-clk enable strobe every DIV cycles.
REQ-011 SHALL have o_level output, width N_CH: debounced, active-high button state.
REQ-012 SHALL have o_press output, width N_CH: one-clk pulse on accepted 0->1 transition.
REQ-013 SHALL have o_release output, width N_CH: one-clk pulse on accepted 1->0 transition.
REQ-014 SHALL have o_long output, width N_CH: one-clk pulse when a channel's level has been high for LONG_TICKS ticks.

Function
REQ-015 Divider SHALL count 0..DIV-1 while ena=1 and hold its value while ena=0.
REQ-016 o_tick SHALL be high for exactly the one cycle in which the divider equals DIV-1 and ena=1; DIV=1 gives o_tick=ena.
REQ-017 Each channel SHALL XOR i_btn with its INVERT bit, then pass it through a 2-flop synchroniser that runs regardless of ena.
REQ-018 Debounce counter SHALL clear in any cycle where the synchronised input equals o_level.
REQ-019 Debounce counter SHALL increment on each o_tick where the synchronised input differs from o_level.
REQ-020 When the debounce counter equals DB_TICKS-1 on an o_tick with the input still differing, o_level SHALL toggle and the counter SHALL clear.
REQ-021 Any return to the old level before acceptance SHALL clear the count, so glitches shorter than DB_TICKS ticks cause no output change.
REQ-022 o_press/o_release SHALL be high for exactly the one cycle in which o_level first shows the new value (registered, aligned with o_level).
REQ-023 Long counter SHALL clear while o_level=0 and increment on o_tick while o_level=1.
REQ-024 When the long counter reaches LONG_TICKS, o_long SHALL pulse once and the counter SHALL saturate; there is no repeat until release and a new press.
REQ-025 Channels SHALL be fully independent; any combination of pulses in the same cycle is legal.
REQ-026 While ena=0, debounce and long counters SHALL freeze, so no level change or pulse can occur.
REQ-027 All counter widths SHALL be $clog2-sized to their maximum value and SHALL never wrap.

Reset
REQ-028 rst_n=0 SHALL immediately force all outputs, synchronisers, the divider and all counters to 0, independent of clk.
REQ-029 Reset asserted mid-debounce or mid-long-press SHALL discard all progress.
REQ-030 A button held through reset SHALL yield a fresh o_press only after the full sync plus DB_TICKS latency following rst_n release.
REQ-031 No pulse output SHALL be generated by reset assertion or deassertion itself.

Verification (N_CH=3, DIV=4, DB_TICKS=3, LONG_TICKS=5, INVERT=3'b100)
REQ-032 Reset/tick: hold rst_n=0 -> all outputs 0; release with ena=1 -> first o_tick on the 4th clk edge, then every 4 clks; drop ena for 6 clks -> no ticks, phase resumes where it stopped.
REQ-033 Clean press: i_btn[0]=1 and held -> o_level[0] rises on the 3rd tick after sync, o_press[0] high 1 clk, o_release/o_long silent.
REQ-034 Bounce: i_btn[1] high for 2 ticks then low -> o_level[1] stays 0, no pulses; then high for 3+ ticks -> accepted.
REQ-035 Long/release: hold ch0 5 ticks past acceptance -> single o_long[0], none after 20 more ticks; release -> o_release[0] after 3 ticks.
REQ-036 Inversion/simultaneity: i_btn[2]=0 (active-low press) together with i_btn[1]=1 -> o_press[2] and o_press[1] in the same cycle.
REQ-037 Reset mid-operation: pulse rst_n low during the 2nd debounce tick with ch0 held -> outputs 0; after release, o_press[0] follows full latency (2 sync + 3 ticks).
